// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with a small output FIFO.
// Optional IW (MOVZ/MOVK) decode enabled by macro IMM_GEN_MOVW_EN.
module imm_gen_pipe #(
   parameter int WIDTH   = 64,
   parameter int INSTR_W = 32,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instruction,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_imm,
   output logic [2:0]         out_fmt
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_D   = 3'd2,
      FMT_B   = 3'd3,
      FMT_CB  = 3'd4,
      FMT_IW  = 3'd5,
      FMT_UNK = 3'd7
   } fmt_e;

   localparam int EW = WIDTH + 3;

   logic [10:0] op;
   logic        is_d, is_cb, is_b;
   logic        is_i, is_iw, is_r;
   logic [WIDTH-1:0] dec_imm;
   fmt_e             dec_fmt;

   assign op = instruction[31:21];

   assign is_d  = (op == 11'b11111000010) ||
                  (op == 11'b11111000000);
   assign is_cb = (instruction[31:24] == 8'b10110100) ||
                  (instruction[31:24] == 8'b10110101);
   assign is_b  = (instruction[31:26] == 6'b000101) ||
                  (instruction[31:26] == 6'b100101);
   assign is_i  = (instruction[31:22] == 10'b1001000100) ||
                  (instruction[31:22] == 10'b1101000100) ||
                  (instruction[31:22] == 10'b1001001000) ||
                  (instruction[31:22] == 10'b1011001000);
   assign is_iw = (instruction[31:23] == 9'b110100101) ||
                  (instruction[31:23] == 9'b111100101);
   assign is_r  = (op == 11'b10001011000) ||
                  (op == 11'b11001011000) ||
                  (op == 11'b10001010000) ||
                  (op == 11'b10101010000) ||
                  (op == 11'b11010011011) ||
                  (op == 11'b11010011010) ||
                  (op == 11'b11010110000);

`ifdef IMM_GEN_MOVW_EN
   logic [63:0] mov_wide;
   // halfword placed at 16*hw; bits above WIDTH fall off
   assign mov_wide = 64'(instruction[20:5]) <<
                     {instruction[22:21], 4'b0000};
`endif

   // format classification and immediate extraction
   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_UNK;
      unique case (1'b1)
         is_d: begin
            dec_fmt = FMT_D;
            dec_imm = {{(WIDTH-9){instruction[20]}},
                       instruction[20:12]};
         end
         is_cb: begin
            dec_fmt = FMT_CB;
            dec_imm = {{(WIDTH-19){instruction[23]}},
                       instruction[23:5]};
         end
         is_b: begin
            dec_fmt = FMT_B;
            dec_imm = {{(WIDTH-26){instruction[25]}},
                       instruction[25:0]};
         end
         is_i: begin
            dec_fmt = FMT_I;
            dec_imm = {{(WIDTH-12){1'b0}},
                       instruction[21:10]};
         end
         is_iw: begin
`ifdef IMM_GEN_MOVW_EN
            dec_fmt = FMT_IW;
            dec_imm = mov_wide[WIDTH-1:0];
`else
            dec_fmt = FMT_UNK;
`endif
         end
         is_r: begin
            dec_fmt = FMT_R;
         end
         default: begin
            dec_fmt = FMT_UNK;
         end
      endcase
   end

   logic [1:0]    count_q, count_d;
   logic          wptr_q, wptr_d;
   logic          rptr_q, rptr_d;
   logic [EW-1:0] last_q, last_d;
   logic [EW-1:0] mem_q [2];
   logic [EW-1:0] head;
   logic          push, pop;

   function automatic logic nxt(input logic p);
      return (DEPTH == 1) ? 1'b0 : ~p;
   endfunction

   assign head      = mem_q[rptr_q];
   assign out_valid = (count_q != 2'd0);
   assign in_ready  = ((count_q < 2'(DEPTH)) || out_ready) && !flush;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // empty buffer shows the last entry that left
   assign out_imm = out_valid ? head[EW-1:3] : last_q[EW-1:3];
   assign out_fmt = out_valid ? head[2:0]    : last_q[2:0];

   // occupancy and pointer next-state; flush wins
   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      last_d  = last_q;
      if (flush) begin
         count_d = 2'd0;
         wptr_d  = 1'b0;
         rptr_d  = 1'b0;
      end else begin
         if (push) wptr_d = nxt(wptr_q);
         if (pop) begin
            rptr_d = nxt(rptr_q);
            last_d = head;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   // control state with async reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 2'd0;
         wptr_q  <= 1'b0;
         rptr_q  <= 1'b0;
         last_q  <= '0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         last_q  <= last_d;
      end
   end

   // entry storage, validity tracked by count
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {dec_imm, dec_fmt};
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe with a queue-based model.
// Honors IMM_GEN_MOVW_EN the same way as the design.
module tb_imm_gen_pipe;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_imm;
   logic [2:0]  out_fmt;

   int checks = 0;
   int failures = 0;

   logic [66:0] mq [$];
   logic [66:0] mlast = '0;

   imm_gen_pipe #(.WIDTH(64), .INSTR_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [66:0] ref_dec(input logic [31:0] x);
      longint v;
      int     f;
      logic [10:0] op;
      op = x[31:21];
      v = 0;
      f = 7;
      if (op == 11'h7C2 || op == 11'h7C0) begin
         f = 2;
         v = longint'(x[20:12]);
         if (v >= 256) v = v - 512;
      end else if (x[31:24] == 8'hB4 || x[31:24] == 8'hB5) begin
         f = 4;
         v = longint'(x[23:5]);
         if (v >= (1 << 18)) v = v - (1 << 19);
      end else if (x[31:26] == 6'b000101 ||
                   x[31:26] == 6'b100101) begin
         f = 3;
         v = longint'(x[25:0]);
         if (v >= (1 << 25)) v = v - (1 << 26);
      end else if (x[31:22] == 10'b1001000100 ||
                   x[31:22] == 10'b1101000100 ||
                   x[31:22] == 10'b1001001000 ||
                   x[31:22] == 10'b1011001000) begin
         f = 1;
         v = longint'(x[21:10]);
      end else if (x[31:23] == 9'b110100101 ||
                   x[31:23] == 9'b111100101) begin
`ifdef IMM_GEN_MOVW_EN
         f = 5;
         v = longint'(x[20:5]) << (16 * int'(x[22:21]));
`else
         f = 7;
         v = 0;
`endif
      end else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                   op == 11'b10001010000 || op == 11'b10101010000 ||
                   op == 11'b11010011011 || op == 11'b11010011010 ||
                   op == 11'b11010110000) begin
         f = 0;
         v = 0;
      end
      return {64'(v), 3'(f)};
   endfunction

   // model advances on each edge, cleared on reset
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mlast = '0;
      end else begin
         logic rdy, psh, pp;
         logic [66:0] e;
         rdy = (mq.size() < DEPTH || out_ready) && !flush;
         psh = in_valid && rdy;
         pp  = (mq.size() > 0) && out_ready && !flush;
         e   = ref_dec(instruction);
         if (flush) begin
            mq.delete();
         end else begin
            if (pp) mlast = mq.pop_front();
            if (psh) mq.push_back(e);
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         logic [66:0] h;
         logic        er;
         h  = (mq.size() > 0) ? mq[0] : mlast;
         er = (mq.size() < DEPTH || out_ready) && !flush;
         chk("in_ready", 64'(in_ready), 64'(er));
         chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
         chk("out_imm", out_imm, h[66:3]);
         chk("out_fmt", 64'(out_fmt), 64'(h[2:0]));
      end
   end

   task automatic step(input logic v, input logic [31:0] ins,
                       input logic ordy, input logic fl);
      in_valid    = v;
      instruction = ins;
      out_ready   = ordy;
      flush       = fl;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_ins();
      logic [31:0] x;
      int k;
      x = $urandom;
      k = $urandom_range(0, 9);
      case (k)
         0: x[31:21] = ($urandom_range(0, 1) != 0) ?
                       11'b11111000010 : 11'b11111000000;
         1: x[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB4 : 8'hB5;
         2: x[31:26] = ($urandom_range(0, 1) != 0) ?
                       6'b000101 : 6'b100101;
         3: x[31:22] = 10'b1001000100;
         4: x[31:22] = 10'b1011001000;
         5: x[31:23] = ($urandom_range(0, 1) != 0) ?
                       9'b110100101 : 9'b111100101;
         6: x[31:21] = 11'b10001011000;
         7: x[31:21] = 11'b11010110000;
         default: ;
      endcase
      return x;
   endfunction

   localparam logic [31:0] LDUR = 32'hF84402C9;
   localparam logic [31:0] CBZ  = 32'hB4FFFF6B;
   localparam logic [31:0] BR64 = 32'h14000040;
   localparam logic [31:0] SUBR = 32'hCB0A028B;
   localparam logic [31:0] ORRR = 32'hAA150149;
   localparam logic [31:0] MOVZ = 32'hD2C24681;

   initial begin
      logic [66:0] r;
      #2;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_imm", out_imm, 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd0);

      r = ref_dec(LDUR);
      chk("pin_ldur", r[66:3], 64'd64);
      r = ref_dec(CBZ);
      chk("pin_cbz", r[66:3], 64'hFFFF_FFFF_FFFF_FFFB);
      r = ref_dec(BR64);
      chk("pin_b", r[66:3], 64'd64);
      r = ref_dec(SUBR);
      chk("pin_sub_fmt", 64'(r[2:0]), 64'd0);

      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      step(1'b1, LDUR, 1'b1, 1'b0);
      chk("ldur_valid", 64'(out_valid), 64'd1);
      chk("ldur_imm", out_imm, 64'd64);
      chk("ldur_fmt", 64'(out_fmt), 64'd2);

      step(1'b1, CBZ, 1'b1, 1'b0);
      chk("cbz_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFB);
      chk("cbz_fmt", 64'(out_fmt), 64'd4);
      step(1'b1, BR64, 1'b1, 1'b0);
      chk("b_imm", out_imm, 64'd64);
      chk("b_fmt", 64'(out_fmt), 64'd3);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("drain_empty", 64'(out_valid), 64'd0);
      chk("hold_imm", out_imm, 64'd64);

      step(1'b1, SUBR, 1'b0, 1'b0);
      step(1'b1, ORRR, 1'b0, 1'b0);
      step(1'b1, LDUR, 1'b0, 1'b0);
      chk("stall_ready", 64'(in_ready), 64'd0);
      chk("stall_imm", out_imm, 64'd0);
      chk("stall_fmt", 64'(out_fmt), 64'd0);
      step(1'b1, LDUR, 1'b0, 1'b0);
      chk("stall_hold", out_imm, 64'd0);
      step(1'b1, LDUR, 1'b1, 1'b0);
      chk("rel_orr_fmt", 64'(out_fmt), 64'd0);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      chk("rel_ldur_imm", out_imm, 64'd64);
      chk("rel_ldur_fmt", 64'(out_fmt), 64'd2);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      step(1'b1, rnd_ins(), 1'b0, 1'b0);
      step(1'b1, rnd_ins(), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, rnd_ins(), 1'b1, 1'b0);
         chk("full_pp_valid", 64'(out_valid), 64'd1);
      end

      step(1'b1, 32'h91000421, 1'b0, 1'b1);
      chk("flush_valid", 64'(out_valid), 64'd0);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      chk("flush_drop", 64'(out_valid), 64'd0);

      step(1'b1, MOVZ, 1'b1, 1'b0);
`ifdef IMM_GEN_MOVW_EN
      chk("movz_imm", out_imm, 64'h0000_1234_0000_0000);
      chk("movz_fmt", 64'(out_fmt), 64'd5);
`else
      chk("movz_imm", out_imm, 64'd0);
      chk("movz_fmt", 64'(out_fmt), 64'd7);
`endif

      step(1'b1, BR64, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_imm", out_imm, 64'd0);
      chk("mid_rst_fmt", 64'(out_fmt), 64'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, rnd_ins(),
              $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0);
      end
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
